// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer-width helper and Gray/binary conversions.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

  localparam int unsigned FIFO_MAX_W = 32;

  typedef logic [FIFO_MAX_W-1:0] fifo_vec_t;

  // Pointer width for a given depth: address bits plus one wrap bit.
  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic fifo_vec_t bin2gray(input fifo_vec_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic fifo_vec_t gray2bin(input fifo_vec_t g);
    fifo_vec_t b;
    b = g;
    for (int unsigned i = 1; i < FIFO_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_ptr_ctrl.sv
// Read-domain pointer controller for the async FIFO: binary/Gray read
// pointers, registered empty / almost-empty / level, and sticky underflow.
module rd_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned PTR_W     = ADDR_W + 1,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              r_en,
  input  logic              clr_underflow,
  input  logic [PTR_W-1:0]  g_wptr_sync,
  output logic [PTR_W-1:0]  b_rptr,
  output logic [PTR_W-1:0]  g_rptr,
  output logic [ADDR_W-1:0] r_addr,
  output logic              empty,
  output logic              almost_empty,
  output logic [PTR_W-1:0]  rd_level,
  output logic              underflow
);

  localparam logic [PTR_W-1:0] AE_T    = PTR_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] DEPTH_V = PTR_W'(DEPTH);

  logic [PTR_W-1:0] r_b_rptr;
  logic [PTR_W-1:0] r_g_rptr;
  logic             r_empty;
  logic             r_almost_empty;
  logic [PTR_W-1:0] r_rd_level;
  logic             r_underflow;

  logic             w_rd_fire;
  logic [PTR_W-1:0] w_b_rptr_next;
  logic [PTR_W-1:0] w_g_rptr_next;
  logic [PTR_W-1:0] w_wbin;
  logic [PTR_W-1:0] w_level_next;
  logic             w_underflow_next;

  always_comb begin
    w_rd_fire        = r_en & ~r_empty;
    w_b_rptr_next    = r_b_rptr + {{(PTR_W-1){1'b0}}, w_rd_fire};
    w_g_rptr_next    = PTR_W'(bin2gray(FIFO_MAX_W'(w_b_rptr_next)));
    w_wbin           = PTR_W'(gray2bin(FIFO_MAX_W'(g_wptr_sync)));
    w_level_next     = w_wbin - w_b_rptr_next;
    // A new underflow event takes priority over a same-cycle clear.
    w_underflow_next = (r_en & r_empty) | (r_underflow & ~clr_underflow);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_b_rptr       <= '0;
      r_g_rptr       <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_rd_level     <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_b_rptr       <= w_b_rptr_next;
      r_g_rptr       <= w_g_rptr_next;
      r_empty        <= (w_g_rptr_next == g_wptr_sync);
      r_almost_empty <= (w_level_next <= AE_T);
      r_rd_level     <= w_level_next;
      r_underflow    <= w_underflow_next;
    end
  end

  assign b_rptr       = r_b_rptr;
  assign g_rptr       = r_g_rptr;
  assign r_addr       = r_b_rptr[ADDR_W-1:0];
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign rd_level     = r_rd_level;
  assign underflow    = r_underflow;

  // A level beyond DEPTH can only come from a corrupted synchronised pointer.
  a_level_legal: assert property (@(posedge rclk) disable iff (!rrst_n)
    w_level_next <= DEPTH_V);

  a_gray_tracks_bin: assert property (@(posedge rclk) disable iff (!rrst_n)
    r_g_rptr == PTR_W'(bin2gray(FIFO_MAX_W'(r_b_rptr))));

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Self-checking bench for rd_ptr_ctrl (DEPTH=16, AE_THRESH=2) against a
// count-based model: total reads/writes as integers, level = writes - reads.
module tb_rd_ptr_ctrl;

  localparam int DEPTH = 16;
  localparam int PW    = 5;
  localparam int AW    = 4;
  localparam int AE    = 2;

  logic          rclk;
  logic          rrst_n;
  logic          r_en;
  logic          clr_underflow;
  logic [PW-1:0] g_wptr_sync;
  logic [PW-1:0] b_rptr;
  logic [PW-1:0] g_rptr;
  logic [AW-1:0] r_addr;
  logic          empty;
  logic          almost_empty;
  logic [PW-1:0] rd_level;
  logic          underflow;

  rd_ptr_ctrl #(.DEPTH(DEPTH), .AE_THRESH(AE)) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .r_en          (r_en),
    .clr_underflow (clr_underflow),
    .g_wptr_sync   (g_wptr_sync),
    .b_rptr        (b_rptr),
    .g_rptr        (g_rptr),
    .r_addr        (r_addr),
    .empty         (empty),
    .almost_empty  (almost_empty),
    .rd_level      (rd_level),
    .underflow     (underflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cumulative reads and writes, plus registered flags.
  int m_rd  = 0;
  int m_wr  = 0;
  bit m_empty = 1'b1;
  bit m_uf    = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input int v);
    logic [PW-1:0] b;
    b = PW'(v % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic check_all();
    int lvl;
    lvl = m_wr - m_rd;
    check("b_rptr",       int'(b_rptr),       m_rd % 32);
    check("g_rptr",       int'(g_rptr),       int'(to_gray(m_rd)));
    check("r_addr",       int'(r_addr),       m_rd % 16);
    check("empty",        int'(empty),        int'(m_empty));
    check("almost_empty", int'(almost_empty), (lvl <= AE) ? 1 : 0);
    check("rd_level",     int'(rd_level),     lvl);
    check("underflow",    int'(underflow),    int'(m_uf));
  endtask

  task automatic check_reset_vals();
    check("rst_b_rptr",   int'(b_rptr),       0);
    check("rst_g_rptr",   int'(g_rptr),       0);
    check("rst_empty",    int'(empty),        1);
    check("rst_ae",       int'(almost_empty), 1);
    check("rst_level",    int'(rd_level),     0);
    check("rst_uf",       int'(underflow),    0);
  endtask

  // One rclk cycle: drive at negedge, update the model at posedge, check #1 later.
  task automatic step(input bit re, input bit clr, input int winc);
    bit fire;
    @(negedge rclk);
    r_en          = re;
    clr_underflow = clr;
    m_wr          = m_wr + winc;
    g_wptr_sync   = to_gray(m_wr);
    @(posedge rclk);
    fire = re && !m_empty;
    if (re && m_empty) m_uf = 1'b1;
    else if (clr)      m_uf = 1'b0;
    if (fire) m_rd = m_rd + 1;
    m_empty = ((m_wr - m_rd) == 0);
    #1;
    check_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int room;
    int winc;
    rrst_n        = 1'b0;
    r_en          = 1'b0;
    clr_underflow = 1'b0;
    g_wptr_sync   = '0;

    // 1. Reset held
    repeat (2) @(posedge rclk);
    #1;
    check_reset_vals();
    @(negedge rclk);
    rrst_n = 1'b1;

    // 2. Fill to 3 without reading
    step(0, 0, 3);
    check("fill_level", int'(rd_level), 3);
    check("fill_empty", int'(empty), 0);
    check("fill_ae", int'(almost_empty), 0);

    // 3. Drain three, then a fourth read request on empty
    step(1, 0, 0);
    check("drain1_ptr", int'(b_rptr), 1);
    check("drain1_ae", int'(almost_empty), 1);
    step(1, 0, 0);
    step(1, 0, 0);
    check("drain3_ptr", int'(b_rptr), 3);
    check("drain3_empty", int'(empty), 1);
    step(1, 0, 0);
    check("drain4_ptr", int'(b_rptr), 3);

    // 4. Underflow: sticky, clear alone, set wins over clear
    step(0, 0, 0);
    check("uf_sticky", int'(underflow), 1);
    step(0, 1, 0);
    check("uf_cleared", int'(underflow), 0);
    step(1, 1, 0);
    check("uf_set_wins", int'(underflow), 1);
    step(0, 1, 0);

    // 5. Wrap: stream until b_rptr reaches 31, then one more read
    guard = 0;
    while ((m_rd % 32) != 31 && guard < 200) begin
      step(!m_empty, 0, ((m_wr - m_rd) < DEPTH) ? 1 : 0);
      guard++;
    end
    check("wrap_reached", ((m_rd % 32) == 31) ? 1 : 0, 1);
    check("wrap_g31", int'(g_rptr), 16);
    check("wrap_addr15", int'(r_addr), 15);
    if (m_empty) step(0, 0, 1);
    step(1, 0, 0);
    check("wrap_b0", int'(b_rptr), 0);
    check("wrap_g0", int'(g_rptr), 0);
    check("wrap_addr0", int'(r_addr), 0);

    // 6. Full level at b_rptr=0, then concurrent read+write
    step(0, 0, DEPTH - (m_wr - m_rd));
    check("full_gw", int'(g_wptr_sync), 24);
    check("full_level", int'(rd_level), 16);
    check("full_empty", int'(empty), 0);
    check("full_ae", int'(almost_empty), 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1);
      check("rw_level", int'(rd_level), 16);
    end

    // Randomized traffic with an asynchronous reset mid-burst
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(negedge rclk);
        r_en = 1'b1;
        #2;
        rrst_n = 1'b0;
        #1;
        check_reset_vals();
        m_rd = 0; m_wr = 0; m_empty = 1'b1; m_uf = 1'b0;
        r_en = 1'b0;
        clr_underflow = 1'b0;
        g_wptr_sync = '0;
        @(negedge rclk);
        rrst_n = 1'b1;
      end
      room = DEPTH - (m_wr - m_rd);
      winc = $urandom_range(0, 2);
      if (winc > room) winc = room;
      step(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
           winc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
